// File: rtl/kgp_seq_pkg.sv
`default_nettype none
// ============================================================================
// kgp_seq_pkg : shared state encodings and constants for the KGP-RISC sequencer
// Revision    : 1.0
// ============================================================================
package kgp_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } seq_state_e;

    localparam int DEF_MEM_TIMEOUT = 255;
    localparam int RET_CNT_W       = 32;

endpackage
`default_nettype wire

// File: rtl/seq_wait_timer.sv
`default_nettype none
// ============================================================================
// seq_wait_timer : memory-wait up-counter, flags expiry at MEM_TIMEOUT
// Revision       : 1.0
// ============================================================================
module seq_wait_timer
    import kgp_seq_pkg::*;
#(
    parameter int TMR_W       = 8,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TMR_W-1:0] c_LIMIT = TMR_W'(MEM_TIMEOUT);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// instr_sequencer : multi-cycle fetch/decode/exec/mem/wb sequencer for KGP-RISC
// Option macro    : SEQ_RETIRE_CNT_EN adds the retired_cnt output
// Revision        : 1.0
// ============================================================================
module instr_sequencer
    import kgp_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int TMR_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 reg_write_i,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic                 halt_i,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_data_phase,
    output logic                 ir_load,
    output logic                 pc_write,
    output logic                 reg_write_en,
    output logic [2:0]           state_o,
    output logic                 halted,
`ifdef SEQ_RETIRE_CNT_EN
    output logic [RET_CNT_W-1:0] retired_cnt,
`endif
    output logic                 fault
);

    seq_state_e state_q;
    logic       mem_req_q;
    logic       mem_we_q;
    logic       mem_dp_q;
    logic       halted_q;
    logic       fault_q;

    logic       w_in_req;
    logic       w_expired;

    assign w_in_req = (state_q == ST_FETCH) || (state_q == ST_MEM);

    seq_wait_timer #(
        .TMR_W       (TMR_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (!w_in_req || mem_ack),
        .en_i      (w_in_req && !mem_ack),
        .expired_o (w_expired)
    );

    // mem_we is latched on MEM entry so it stays stable for the whole request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_dp_q  <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_q   <= ST_FETCH;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                        mem_dp_q  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        state_q   <= ST_DECODE;
                        mem_req_q <= 1'b0;
                    end else if (w_expired) begin
                        state_q   <= ST_FAULT;
                        mem_req_q <= 1'b0;
                        fault_q   <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (halt_i) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (mem_read_i && mem_write_i) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end else if (mem_read_i || mem_write_i) begin
                        state_q   <= ST_MEM;
                        mem_req_q <= 1'b1;
                        mem_dp_q  <= 1'b1;
                        mem_we_q  <= mem_write_i;
                    end else if (reg_write_i) begin
                        state_q <= ST_WB;
                    end else begin
                        state_q   <= run ? ST_FETCH : ST_IDLE;
                        mem_req_q <= run;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_dp_q  <= 1'b0;
                        if (mem_we_q) begin
                            state_q   <= run ? ST_FETCH : ST_IDLE;
                            mem_req_q <= run;
                        end else begin
                            state_q <= ST_WB;
                        end
                    end else if (w_expired) begin
                        state_q   <= ST_FAULT;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_dp_q  <= 1'b0;
                        fault_q   <= 1'b1;
                    end
                end
                ST_WB: begin
                    state_q   <= run ? ST_FETCH : ST_IDLE;
                    mem_req_q <= run;
                end
                ST_HALT:  state_q <= ST_HALT;
                ST_FAULT: state_q <= ST_FAULT;
                default:  state_q <= ST_FAULT;
            endcase
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_data_phase = mem_dp_q;
    assign halted         = halted_q;
    assign fault          = fault_q;
    assign state_o        = state_q;

    assign ir_load      = (state_q == ST_FETCH) && mem_ack;
    assign reg_write_en = (state_q == ST_WB);
    assign pc_write     = (state_q == ST_WB)
                       || ((state_q == ST_MEM) && mem_ack && mem_we_q)
                       || ((state_q == ST_EXEC) && !mem_read_i && !mem_write_i && !reg_write_i);

`ifdef SEQ_RETIRE_CNT_EN
    logic [RET_CNT_W-1:0] retired_cnt_q;
    logic [RET_CNT_W-1:0] retired_cnt_d;

    // pc_write is never asserted in HALT/FAULT, so the count freezes there
    assign retired_cnt_d = retired_cnt_q + RET_CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_cnt_q <= '0;
        end else if (pc_write) begin
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle sequencer for the KGP-RISC datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives IR/PC/register-file enables and a req/ack handshake to the shared instruction/data memory.
- Takes class bits (reg_write, mem_read, mem_write, halt) from the combinational control_unit, whose outputs settle during the DECODE cycle.

Parameters:
- MEM_TIMEOUT, 255, maximum cycles spent waiting for mem_ack in FETCH or MEM before entering FAULT.
- TMR_W, 8, width of the wait counter; must satisfy 2**TMR_W > MEM_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- run  input  1  level; enables leaving IDLE and continuing after each retire
- reg_write_i  input  1  control_unit RegWrite
- mem_read_i  input  1  control_unit MemRead
- mem_write_i  input  1  control_unit MemWrite
- halt_i  input  1  control_unit halt
- mem_ack  input  1  memory completes the current request this cycle
- mem_req  output  1  memory request, held until ack
- mem_we  output  1  write qualifier, valid only with mem_req
- mem_data_phase  output  1  0 = instruction address (PC), 1 = data address (drives AdSel mux)
- ir_load  output  1  capture the instruction word into IR
- pc_write  output  1  update PC (next-PC mux selected elsewhere); marks retire
- reg_write_en  output  1  register-file write strobe
- state_o  output  3  current state encoding
- halted  output  1  sticky halt indicator
- fault  output  1  sticky fault indicator

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- Reset is asynchronous, active-high:
  - state = IDLE, wait counter = 0, all outputs 0.
  - mem_req drops immediately, even mid-transaction.
- Outputs are Moore, except ir_load, pc_write and reg_write_en, which are single-cycle pulses as listed below.
- IDLE: run=1 -> FETCH.
- FETCH:
  - mem_req=1, mem_we=0, mem_data_phase=0.
  - On mem_ack: ir_load=1 that cycle, then -> DECODE.
- DECODE: one cycle.
  - halt_i=1 -> HALT.
  - Otherwise -> EXEC.
- EXEC: one cycle.
  - mem_read_i and mem_write_i both 1 -> FAULT.
  - Either of them 1 -> MEM.
  - Else reg_write_i=1 -> WB.
  - Else (branch/NOP): pc_write=1, then -> FETCH if run, else IDLE.
- MEM:
  - mem_req=1, mem_data_phase=1, mem_we=mem_write_i.
  - On ack with a load -> WB.
  - On ack with a store: pc_write=1 that cycle, then -> FETCH if run, else IDLE.
- WB: reg_write_en=1 and pc_write=1 for one cycle, then -> FETCH if run, else IDLE.
- HALT: halted=1, all strobes 0; held until reset.
- FAULT: fault=1, all strobes 0; held until reset.
- Handshake:
  - mem_req, mem_we and mem_data_phase stay stable from assertion until the ack cycle.
  - mem_req is deasserted the cycle after ack.
  - Ack outside FETCH/MEM is ignored.
- Wait counter:
  - Cleared on entry to FETCH/MEM; increments each cycle without ack.
  - Count == MEM_TIMEOUT without ack -> FAULT.
  - Ack arriving in the same cycle the count reaches MEM_TIMEOUT wins; no fault.
- run is sampled only in IDLE and at retire. Deassertion mid-instruction lets that instruction complete.
- Cycle counts with zero-wait memory (ack in first request cycle): ALU/imm = 4, load = 5, store = 4, branch = 3.

Optional Feature:
- Macro: SEQ_RETIRE_CNT_EN.
- Defined:
  - Adds output retired_cnt[31:0]: reset 0, +1 on every pc_write cycle, wraps 0xFFFFFFFF -> 0.
  - Frozen in HALT/FAULT.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package kgp_seq_pkg:
  - state enum and its 3-bit encodings;
  - default MEM_TIMEOUT;
  - retire counter width constant.
- One sub-module: seq_wait_timer.
  - Parameterised TMR_W up-counter with clear and enable.
  - Asserts expired at MEM_TIMEOUT.
  - Instantiated once and shared by FETCH and MEM.

Test Plan:
- Reset held, then run=1, ADDI (reg_write_i=1), ack in first cycle -> states 1,2,3,5; ir_load at cycle 1; reg_write_en and pc_write in cycle 4.
- LW with a 3-cycle data wait -> MEM lasts 4 cycles with mem_req=1, mem_data_phase=1, mem_we=0; then WB; load retires at cycle 8.
- SW -> mem_we=1 throughout MEM; pc_write on the ack cycle; no WB; reg_write_en never asserted.
- halt_i=1 in DECODE -> HALT; halted=1; mem_req stays 0 for 20 cycles despite run=1; reset returns to IDLE.
- mem_ack never asserted in FETCH with MEM_TIMEOUT=4 -> FAULT after 4 waiting cycles; fault=1; mem_req=0. Separately, mem_read_i=mem_write_i=1 in EXEC -> FAULT.
- reset pulsed mid-MEM -> mem_req=0 asynchronously; state_o=0. With SEQ_RETIRE_CNT_EN defined: 3 retired instructions give retired_cnt=3, and preload 0xFFFFFFFF + 1 retire gives 0.
